// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared next-PC select codes, reset PC and nop word for the fetch stage
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    NPC_SEL_PC4 = 2'b00,
    NPC_SEL_BR  = 2'b01,
    NPC_SEL_J   = 2'b10,
    NPC_SEL_JR  = 2'b11
  } npc_sel_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_npc_calc.sv
// rtl/fetch_stage_npc_calc.sv - combinational next-PC mux; redirect targets are formed from id_pc
module npc_calc
  import fetch_stage_pkg::*;
(
  input  logic [1:0]  npc_sel,
  input  logic        branch_cond,
  input  logic [25:0] id_imm26,
  input  logic [31:0] id_rs_fwd,
  input  logic [31:0] if_pc,
  input  logic [31:0] id_pc,
  output logic [31:0] npc
);

  logic [31:0] if_pc4;
  logic [31:0] id_pc4;
  logic [31:0] br_off;

  assign if_pc4 = if_pc + 32'd4;
  assign id_pc4 = id_pc + 32'd4;
  assign br_off = {{14{id_imm26[15]}}, id_imm26[15:0], 2'b00};

  always_comb begin
    npc = if_pc4;
    case (npc_sel_e'(npc_sel))
      NPC_SEL_PC4: npc = if_pc4;
      NPC_SEL_BR:  npc = branch_cond ? (id_pc4 + br_off) : if_pc4;
      NPC_SEL_J:   npc = {id_pc4[31:28], id_imm26, 2'b00};
      NPC_SEL_JR:  npc = id_rs_fwd;
      default:     npc = if_pc4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC register, next-PC select and IF/ID register
// Optional FETCH_ADDR_CHECK_EN: flag misaligned/out-of-IM fetches and latch a nop instead.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          IM_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        branch_cond,
  input  logic [25:0] id_imm26,
  input  logic [31:0] id_rs_fwd,
  input  logic [31:0] im_instr,
  output logic [31:0] if_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_fetch_err
);

  logic [31:0] npc;
  logic        fetch_err;

  npc_calc u_npc_calc (
    .npc_sel     (npc_sel),
    .branch_cond (branch_cond),
    .id_imm26    (id_imm26),
    .id_rs_fwd   (id_rs_fwd),
    .if_pc       (if_pc),
    .id_pc       (id_pc),
    .npc         (npc)
  );

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic [31:0] PC_LIMIT = PC_RESET + (32'(IM_DEPTH) << 2);

  assign fetch_err = (if_pc[1:0] != 2'b00) || (if_pc < PC_RESET) || (if_pc >= PC_LIMIT);
`else
  logic [31:0] unused_im_depth;

  assign unused_im_depth = 32'(IM_DEPTH);
  assign fetch_err       = 1'b0;
`endif

  // The delay-slot word fetched during a redirect is always latched; no flush path exists.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_pc        <= PC_RESET;
      id_instr     <= NOP_WORD;
      id_pc        <= PC_RESET;
      id_pc8       <= PC_RESET + 32'd8;
      id_fetch_err <= 1'b0;
    end else if (!stall) begin
      if_pc        <= npc;
      id_pc        <= if_pc;
      id_pc8       <= if_pc + 32'd8;
      id_instr     <= fetch_err ? NOP_WORD : im_instr;
      id_fetch_err <= fetch_err;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed table-driven bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic        branch_cond = 1'b0;
  logic [25:0] id_imm26 = 26'h0;
  logic [31:0] id_rs_fwd = 32'h0;
  logic [31:0] im_instr;
  logic [31:0] if_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic        id_fetch_err;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .npc_sel      (npc_sel),
    .branch_cond  (branch_cond),
    .id_imm26     (id_imm26),
    .id_rs_fwd    (id_rs_fwd),
    .im_instr     (im_instr),
    .if_pc        (if_pc),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_pc8       (id_pc8),
    .id_fetch_err (id_fetch_err)
  );

  function automatic logic [31:0] im_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  assign im_instr = im_word(if_pc);

  function automatic logic exp_err(input logic [31:0] a);
`ifdef FETCH_ADDR_CHECK_EN
    return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a >= 32'h0000_7000);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] a);
    return exp_err(a) ? 32'h0 : im_word(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s actual=%h required=%h", name, act, req);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idif(input string tag, input logic [31:0] pc_exp, input logic [31:0] idpc_exp);
    chk({tag, ".if_pc"}, if_pc, pc_exp);
    chk({tag, ".id_pc"}, id_pc, idpc_exp);
    chk({tag, ".id_pc8"}, id_pc8, idpc_exp + 32'd8);
    chk({tag, ".id_instr"}, id_instr, exp_instr(idpc_exp));
    chk({tag, ".id_err"}, 32'(id_fetch_err), 32'(exp_err(idpc_exp)));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".if_pc"}, if_pc, 32'h3000);
    chk({tag, ".id_instr"}, id_instr, 32'h0);
    chk({tag, ".id_pc"}, id_pc, 32'h3000);
    chk({tag, ".id_pc8"}, id_pc8, 32'h3008);
    chk({tag, ".id_err"}, 32'(id_fetch_err), 32'h0);
  endtask

  typedef struct {
    logic [31:0] pc_set;
    logic [1:0]  sel;
    logic        cond;
    logic [25:0] imm26;
    logic [31:0] rs;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'h0000_3010, 2'b01, 1'b1, 26'h000_FFFE, 32'h0, 32'h0000_300C};
    vecs[1] = '{32'h0000_3010, 2'b01, 1'b0, 26'h000_FFFE, 32'h0, 32'h0000_3018};
    vecs[2] = '{32'h0000_3020, 2'b10, 1'b0, 26'h000_0C10, 32'h0, 32'h0000_3040};
    vecs[3] = '{32'h0000_3000, 2'b00, 1'b1, 26'h000_FFFE, 32'h0, 32'h0000_3008};
    vecs[4] = '{32'h0000_3100, 2'b11, 1'b0, 26'h000_0000, 32'h0000_3400, 32'h0000_3400};
    vecs[5] = '{32'h0000_3010, 2'b01, 1'b1, 26'h000_0004, 32'h0, 32'h0000_3024};
    vecs[6] = '{32'hFFFF_FFF8, 2'b00, 1'b0, 26'h000_0000, 32'h0, 32'h0000_0000};
    vecs[7] = '{32'h2FFF_FFFC, 2'b10, 1'b0, 26'h3FF_FFFF, 32'h0, 32'h3FFF_FFFC};

    // reset held two cycles
    reset = 1'b1;
    step();
    step();
    chk_reset("reset");
    reset = 1'b0;

    // sequential fetch
    npc_sel = 2'b00;
    step();
    chk_idif("seq0", 32'h3004, 32'h3000);
    step();
    chk_idif("seq1", 32'h3008, 32'h3004);
    step();
    chk_idif("seq2", 32'h300C, 32'h3008);

    // table: jr to pc_set, advance so id_pc=pc_set, then apply the redirect under test
    for (int i = 0; i < 8; i++) begin
      npc_sel = 2'b11;
      id_rs_fwd = vecs[i].pc_set;
      step();
      npc_sel = 2'b00;
      step();
      npc_sel = vecs[i].sel;
      branch_cond = vecs[i].cond;
      id_imm26 = vecs[i].imm26;
      id_rs_fwd = vecs[i].rs;
      step();
      chk_idif($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].pc_set + 32'd4);
      branch_cond = 1'b0;
    end

    // stall freezes PC and IF/ID while a jr is presented
    npc_sel = 2'b11;
    id_rs_fwd = 32'h3100;
    step();
    npc_sel = 2'b00;
    step();
    stall = 1'b1;
    npc_sel = 2'b11;
    id_rs_fwd = 32'h3400;
    step();
    chk_idif("stall0", 32'h3104, 32'h3100);
    step();
    chk_idif("stall1", 32'h3104, 32'h3100);
    stall = 1'b0;
    step();
    chk_idif("unstall", 32'h3400, 32'h3104);

    // reset during stall and redirect wins
    stall = 1'b1;
    reset = 1'b1;
    step();
    chk_reset("rst_stall");
    reset = 1'b0;
    stall = 1'b0;

    // misaligned jr target
    npc_sel = 2'b11;
    id_rs_fwd = 32'h3002;
    step();
    npc_sel = 2'b00;
    step();
    chk_idif("misalign", 32'h3006, 32'h3002);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
